instr_fetch_stage: RTL and testbench

- Instruction-fetch stage for the single-issue MIPS-style datapath. Owns the PC, drives instruction memory, and holds the IF/ID pipeline register.
- The IF/ID register feeds opcode and funct to the control decoder directly downstream.
- Takes branch and jump resolution (Beq, Bne, Jump, ALU zero, immediate, jump field) back from decode/execute to redirect the PC.
- Handles a variable-latency instruction memory and a downstream stall.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/instr_fetch_stage_if.sv | 29 ++
 rtl/next_pc_calc.sv | 40 ++++
 rtl/instr_fetch_stage.sv | 123 ++++++++++++
 tb/tb_instr_fetch_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style fetch/decode slice.
// Contents: fetch FSM state encoding, the bubble instruction word, and the
// bit positions of the instruction fields read by fetch and decode.
package mips_pkg;

    typedef enum logic [0:0] {
        S_FETCH = 1'b0,
        S_HELD  = 1'b1
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int unsigned OPCODE_HI = 31;
    localparam int unsigned OPCODE_LO = 26;
    localparam int unsigned FUNCT_HI  = 5;
    localparam int unsigned FUNCT_LO  = 0;
    localparam int unsigned IMM_HI    = 15;
    localparam int unsigned IMM_LO    = 0;
    localparam int unsigned TARGET_HI = 25;
    localparam int unsigned TARGET_LO = 0;

endpackage

// File: rtl/instr_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// Signals:
//   imem_addr  - fetch address (driven by the fetch stage)
//   imem_req   - fetch request (driven by the fetch stage)
//   imem_rdata - instruction word, valid when imem_ready=1 (driven by memory)
//   imem_ready - memory returns the word for imem_addr this cycle
// Modports: master = fetch stage, slave = instruction memory.
interface instr_fetch_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic [31:0]       imem_rdata;
    logic              imem_ready;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_rdata,
        output imem_ready
    );
endinterface

// File: rtl/next_pc_calc.sv
// Combinational branch/jump resolution for the fetch stage.
// Ports:
//   br_beq, br_bne, br_jump - control-flow kind resolving this cycle
//   alu_zero                - ALU zero flag paired with the branch
//   br_pc4                  - PC+4 of the resolving instruction
//   br_imm                  - 16-bit branch offset (words, signed)
//   br_target               - 26-bit jump field
//   taken                   - PC must be redirected this cycle
//   target                  - redirect address (jump wins over branch)
module next_pc_calc
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic                     br_beq,
    input  logic                     br_bne,
    input  logic                     br_jump,
    input  logic                     alu_zero,
    input  logic [ADDR_W-1:0]        br_pc4,
    input  logic [IMM_HI:IMM_LO]     br_imm,
    input  logic [TARGET_HI:TARGET_LO] br_target,
    output logic                     taken,
    output logic [ADDR_W-1:0]        target
);

    logic [ADDR_W-1:0] branch_off;
    logic [ADDR_W-1:0] branch_tgt;
    logic [ADDR_W-1:0] jump_tgt;

    // Sign-extended word offset converted to a byte offset.
    assign branch_off = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
    assign branch_tgt = br_pc4 + branch_off;
    assign jump_tgt   = {br_pc4[ADDR_W-1:28], br_target, 2'b00};

    always_comb begin
        taken  = (br_beq & alu_zero) | (br_bne & ~alu_zero) | br_jump;
        target = br_jump ? jump_tgt : branch_tgt;
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and holds
// the IF/ID pipeline register for a single-issue MIPS-style datapath.
// Ports:
//   clk, rst_n      - clock (rising edge), async active-low reset
//   imem            - instruction-memory bus (master side)
//   stall           - downstream cannot accept a new IF/ID entry
//   br_*, alu_zero  - branch/jump resolution fed back from decode/execute
//   if_id_instr/pc4/valid - IF/ID register contents
//   opcode, funct   - instruction fields for the control decoder
//   redirect        - registered 1-cycle pulse per taken redirect
// A word that arrives while stalled is parked in a hold buffer (S_HELD) and
// no new request is issued until it has been handed downstream.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    instr_fetch_stage_if.master        imem,
    input  logic                       stall,
    input  logic                       br_beq,
    input  logic                       br_bne,
    input  logic                       br_jump,
    input  logic                       alu_zero,
    input  logic [ADDR_W-1:0]          br_pc4,
    input  logic [IMM_HI:IMM_LO]       br_imm,
    input  logic [TARGET_HI:TARGET_LO] br_target,
    output logic [31:0]                if_id_instr,
    output logic [ADDR_W-1:0]          if_id_pc4,
    output logic                       if_id_valid,
    output logic [5:0]                 opcode,
    output logic [5:0]                 funct,
    output logic                       redirect
);

    fetch_state_e      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus4;
    logic [31:0]       hold_instr;
    logic [ADDR_W-1:0] hold_pc4;
    logic              taken;
    logic [ADDR_W-1:0] target;

    next_pc_calc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc_calc (
        .br_beq    (br_beq),
        .br_bne    (br_bne),
        .br_jump   (br_jump),
        .alu_zero  (alu_zero),
        .br_pc4    (br_pc4),
        .br_imm    (br_imm),
        .br_target (br_target),
        .taken     (taken),
        .target    (target)
    );

    assign pc_plus4       = pc + ADDR_W'(4);
    assign imem.imem_addr = pc;
    assign imem.imem_req  = (state == S_FETCH);
    assign opcode         = if_id_instr[OPCODE_HI:OPCODE_LO];
    assign funct          = if_id_instr[FUNCT_HI:FUNCT_LO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
            hold_instr  <= NOP_INSTR;
            hold_pc4    <= '0;
            redirect    <= 1'b0;
        end else begin
            redirect <= taken;
            case (state)
                S_FETCH: begin
                    if (taken) begin
                        // Any response this cycle belongs to the wrong path.
                        pc          <= target;
                        if_id_instr <= NOP_INSTR;
                        if_id_pc4   <= '0;
                        if_id_valid <= 1'b0;
                    end else if (imem.imem_ready && !stall) begin
                        if_id_instr <= imem.imem_rdata;
                        if_id_pc4   <= pc_plus4;
                        if_id_valid <= 1'b1;
                        pc          <= pc_plus4;
                    end else if (imem.imem_ready && stall) begin
                        hold_instr <= imem.imem_rdata;
                        hold_pc4   <= pc_plus4;
                        state      <= S_HELD;
                    end else if (!stall) begin
                        if_id_instr <= NOP_INSTR;
                        if_id_pc4   <= '0;
                        if_id_valid <= 1'b0;
                    end
                end
                S_HELD: begin
                    if (taken) begin
                        pc          <= target;
                        if_id_instr <= NOP_INSTR;
                        if_id_pc4   <= '0;
                        if_id_valid <= 1'b0;
                        hold_instr  <= NOP_INSTR;
                        hold_pc4    <= '0;
                        state       <= S_FETCH;
                    end else if (!stall) begin
                        if_id_instr <= hold_instr;
                        if_id_pc4   <= hold_pc4;
                        if_id_valid <= 1'b1;
                        pc          <= pc_plus4;
                        state       <= S_FETCH;
                    end
                end
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_beq;
    logic        br_bne;
    logic        br_jump;
    logic        alu_zero;
    logic [31:0] br_pc4;
    logic [15:0] br_imm;
    logic [25:0] br_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        redirect;

    int checks = 0;
    int errors = 0;

    instr_fetch_stage_if #(.ADDR_W(32)) imem_bus ();

    instr_fetch_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (imem_bus.master),
        .stall       (stall),
        .br_beq      (br_beq),
        .br_bne      (br_bne),
        .br_jump     (br_jump),
        .alu_zero    (alu_zero),
        .br_pc4      (br_pc4),
        .br_imm      (br_imm),
        .br_target   (br_target),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .opcode      (opcode),
        .funct       (funct),
        .redirect    (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [31:0] rdata;
        logic        stl;
        logic        beq;
        logic        bne;
        logic        jmp;
        logic        zero;
        logic [31:0] pc4;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] e_addr;
        logic        e_req;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic        e_redir;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_addr, input logic e_req,
                             input logic [31:0] e_instr, input logic [31:0] e_pc4,
                             input logic e_valid, input logic e_redir);
        logic [31:0] ei;
        ei = e_instr;
        check({tag, " imem_addr"}, imem_bus.imem_addr, e_addr);
        check({tag, " imem_req"}, 32'(imem_bus.imem_req), 32'(e_req));
        check({tag, " if_id_instr"}, if_id_instr, e_instr);
        check({tag, " if_id_pc4"}, if_id_pc4, e_pc4);
        check({tag, " if_id_valid"}, 32'(if_id_valid), 32'(e_valid));
        check({tag, " redirect"}, 32'(redirect), 32'(e_redir));
        check({tag, " opcode"}, 32'(opcode), 32'(ei[31:26]));
        check({tag, " funct"}, 32'(funct), 32'(ei[5:0]));
    endtask

    task automatic drive(input logic rdy, input logic [31:0] rdata, input logic stl,
                         input logic beq, input logic bne, input logic jmp, input logic zero,
                         input logic [31:0] pc4, input logic [15:0] imm, input logic [25:0] tgt);
        imem_bus.imem_ready = rdy;
        imem_bus.imem_rdata = rdata;
        stall     = stl;
        br_beq    = beq;
        br_bne    = bne;
        br_jump   = jmp;
        alu_zero  = zero;
        br_pc4    = pc4;
        br_imm    = imm;
        br_target = tgt;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
    endtask

    initial begin
        //        rdy rdata         stl beq bne jmp zro pc4           imm      tgt
        //        e_addr        req e_instr       e_pc4         vld rdr
        vecs[0]  = '{1, 32'h2008_0005, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0004, 1, 32'h2008_0005, 32'h0000_0004, 1, 0};
        vecs[1]  = '{1, 32'h0000_0020, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0008, 1, 32'h0000_0020, 32'h0000_0008, 1, 0};
        // Memory wait: three bubbles, PC held at 8.
        vecs[2]  = '{0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0008, 1, 32'h0, 32'h0, 0, 0};
        vecs[3]  = '{0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0008, 1, 32'h0, 32'h0, 0, 0};
        vecs[4]  = '{0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0008, 1, 32'h0, 32'h0, 0, 0};
        vecs[5]  = '{1, 32'h8C09_0004, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_000C, 1, 32'h8C09_0004, 32'h0000_000C, 1, 0};
        vecs[6]  = '{1, 32'h0109_5020, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0010, 1, 32'h0109_5020, 32'h0000_0010, 1, 0};
        // Stall with word ready at pc=0x10: hold it, IF/ID frozen.
        vecs[7]  = '{1, 32'hAC0A_0008, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0010, 0, 32'h0109_5020, 32'h0000_0010, 1, 0};
        vecs[8]  = '{1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0010, 0, 32'h0109_5020, 32'h0000_0010, 1, 0};
        vecs[9]  = '{0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0014, 1, 32'hAC0A_0008, 32'h0000_0014, 1, 0};
        // Waiting and stalled: IF/ID unchanged.
        vecs[10] = '{0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0014, 1, 32'hAC0A_0008, 32'h0000_0014, 1, 0};
        // beq taken: 0x20 + (-2 << 2) = 0x18, response discarded.
        vecs[11] = '{1, 32'h1234_5678, 0, 1, 0, 0, 1, 32'h0000_0020, 16'hFFFE, 26'h0,
                     32'h0000_0018, 1, 32'h0, 32'h0, 0, 1};
        vecs[12] = '{0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0018, 1, 32'h0, 32'h0, 0, 0};
        // beq not taken: normal fetch.
        vecs[13] = '{1, 32'h1111_0000, 0, 1, 0, 0, 0, 32'h0000_0020, 16'hFFFE, 26'h0,
                     32'h0000_001C, 1, 32'h1111_0000, 32'h0000_001C, 1, 0};
        // bne taken: 0x100 + 0x10 = 0x110.
        vecs[14] = '{0, 32'h0, 0, 0, 1, 0, 0, 32'h0000_0100, 16'h0004, 26'h0,
                     32'h0000_0110, 1, 32'h0, 32'h0, 0, 1};
        vecs[15] = '{1, 32'h2222_0000, 1, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h0000_0110, 0, 32'h0, 32'h0, 0, 0};
        // Jump while stalled in S_HELD: hold cancelled, pc=0x40000400.
        vecs[16] = '{0, 32'h0, 1, 0, 0, 1, 0, 32'h4000_0010, 16'h0, 26'h000_0100,
                     32'h4000_0400, 1, 32'h0, 32'h0, 0, 1};
        vecs[17] = '{1, 32'h3333_0000, 0, 0, 0, 0, 0, 32'h0, 16'h0, 26'h0,
                     32'h4000_0404, 1, 32'h3333_0000, 32'h4000_0404, 1, 0};
        // Jump beats a simultaneous taken beq: target {0,3,00} = 0xC.
        vecs[18] = '{1, 32'h4444_0000, 0, 1, 0, 1, 1, 32'h0000_0008, 16'h0010, 26'h000_0003,
                     32'h0000_000C, 1, 32'h0, 32'h0, 0, 1};

        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].rdy, vecs[i].rdata, vecs[i].stl, vecs[i].beq, vecs[i].bne,
                  vecs[i].jmp, vecs[i].zero, vecs[i].pc4, vecs[i].imm, vecs[i].tgt);
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_req, vecs[i].e_instr,
                      vecs[i].e_pc4, vecs[i].e_valid, vecs[i].e_redir);
        end

        // Async reset in the middle of S_HELD.
        drive(1'b1, 32'h5555_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        @(posedge clk);
        #1;
        check_all("held_pre_rst", 32'h0000_000C, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", 32'h0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h2008_0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        @(posedge clk);
        #1;
        check_all("post_rst", 32'h0000_0004, 1'b1, 32'h2008_0005, 32'h0000_0004, 1'b1, 1'b0);

        // PC+4 wraps: jump to 0xFFFFFFFC, then fetch.
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hF000_0000, 16'h0, 26'h3FF_FFFF);
        @(posedge clk);
        #1;
        check_all("wrap_jump", 32'hFFFF_FFFC, 1'b1, 32'h0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 32'h0000_0025, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0);
        @(posedge clk);
        #1;
        check_all("wrap_fetch", 32'h0000_0000, 1'b1, 32'h0000_0025, 32'h0000_0000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
